// File: rtl/can_if_pkg.sv
// Shared constants for the quad CAN interface shim:
// channel codes, register word indices and bit positions.
package can_if_pkg;

   localparam int NCH = 4;

   localparam logic [3:0] CH_CODE [NCH] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000
   };

   localparam logic [2:0] W_CTRL = 3'd0;
   localparam logic [2:0] W_STAT = 3'd1;

   localparam int B_SRST    = 0;
   localparam int B_TX_EN   = 1;
   localparam int B_TX_LVL  = 2;
   localparam int B_RX_LVL  = 0;
   localparam int B_RX_FALL = 1;

   localparam logic [31:0] RESET_DO = 32'h0;

endpackage

// File: rtl/can_if_quad_if.sv
// OPB slave-side bundle for the quad CAN shim:
// shared address/data plus per-channel strobes and read data.
interface can_if_quad_if;
   logic [31:0] OPB_DI;
   logic [15:0] OPB_ADDR;
   logic        CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE;
   logic        CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE;
   logic [31:0] CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO;

   modport slave (
      input  OPB_DI, OPB_ADDR,
      input  CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE,
      input  CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE,
      output CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO
   );

   modport master (
      output OPB_DI, OPB_ADDR,
      output CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE,
      output CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE,
      input  CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO
   );
endinterface

// File: rtl/can_if_chan.sv
// One CAN channel: address decode, mailbox, CTRL/STAT,
// RX synchroniser with sticky fall detect, registered TX drive.
module can_if_chan #(
   parameter logic [3:0] CH_CODE = 4'b0001,
   parameter int NREG    = 8,
   parameter int SYNC_FF = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] di,
   input  logic [15:0] addr,
   input  logic        re,
   input  logic        we,
   output logic [31:0] dout,
   output logic        can_tx,
   input  logic        can_rx
);
   import can_if_pkg::*;

   localparam int AW = $clog2(NREG);

   logic              sel;
   logic              ctl;
   logic [AW-1:0]     widx;
   logic [2:0]        cidx;
   logic              acc_re;
   logic              acc_we;
   logic              ctrl_wr;
   logic              stat_rd;
   logic              srst;
   logic [31:0]       mbx [NREG];
   logic              tx_en;
   logic              tx_lvl;
   logic              en_nx;
   logic              lvl_nx;
   logic [SYNC_FF-1:0] sync;
   logic              rx_s;
   logic              rx_d;
   logic              fall;
   logic              rx_fall;
   logic [31:0]       rdata;

   assign sel     = (addr[14:11] == CH_CODE);
   assign ctl     = addr[15];
   assign widx    = addr[AW+1:2];
   assign cidx    = addr[4:2];
   assign acc_re  = re & sel;
   assign acc_we  = we & sel;
   assign ctrl_wr = acc_we & ctl & (cidx == W_CTRL);
   assign stat_rd = acc_re & ctl & (cidx == W_STAT);
   assign srst    = ctrl_wr & di[B_SRST];

   assign en_nx  = ctrl_wr ? di[B_TX_EN]  : tx_en;
   assign lvl_nx = ctrl_wr ? di[B_TX_LVL] : tx_lvl;

   assign rx_s = sync[SYNC_FF-1];
   assign fall = rx_d & ~rx_s;

   always_comb begin
      rdata = '0;
      if (!ctl) begin
         rdata = mbx[widx];
      end else begin
         unique case (1'b1)
            (cidx == W_CTRL): begin
               rdata[B_TX_EN]  = tx_en;
               rdata[B_TX_LVL] = tx_lvl;
            end
            (cidx == W_STAT): begin
               rdata[B_RX_LVL]  = rx_s;
               rdata[B_RX_FALL] = rx_fall;
            end
            default: ;
         endcase
      end
   end

   // TX is driven from the next-state CTRL so the pin follows the write edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_en   <= 1'b0;
         tx_lvl  <= 1'b0;
         can_tx  <= 1'b1;
         sync    <= '1;
         rx_d    <= 1'b1;
         rx_fall <= 1'b0;
         dout    <= RESET_DO;
      end else begin
         tx_en  <= en_nx;
         tx_lvl <= lvl_nx;
         can_tx <= en_nx ? lvl_nx : 1'b1;
         sync   <= {sync[SYNC_FF-2:0], can_rx};
         rx_d   <= rx_s;
         if (srst)
            rx_fall <= 1'b0;
         else if (fall)
            rx_fall <= 1'b1;
         else if (stat_rd)
            rx_fall <= 1'b0;
         if (re)
            dout <= sel ? rdata : RESET_DO;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            mbx[i] <= '0;
      end else if (srst) begin
         for (int i = 0; i < NREG; i++)
            mbx[i] <= '0;
      end else if (acc_we && !ctl) begin
         mbx[widx] <= di;
      end
   end

endmodule

// File: rtl/can_if_quad.sv
// Four independent CAN channels sharing one OPB slave bus;
// each channel owns its strobes, read data and TX/RX pins.
module can_if_quad #(
   parameter int NREG    = 8,
   parameter int SYNC_FF = 2
) (
   input  logic OPB_CLK,
   input  logic OPB_RST,
   can_if_quad_if.slave bus,
   output logic CAN_TX1,
   output logic CAN_TX2,
   output logic CAN_TX3,
   output logic CAN_TX4,
   input  logic CAN_RX1,
   input  logic CAN_RX2,
   input  logic CAN_RX3,
   input  logic CAN_RX4
);
   import can_if_pkg::*;

   logic [NCH-1:0] re;
   logic [NCH-1:0] we;
   logic [NCH-1:0] rx;
   logic [NCH-1:0] tx;
   logic [31:0]    dout [NCH];

   assign re = {bus.CAN4_RE, bus.CAN3_RE, bus.CAN2_RE, bus.CAN1_RE};
   assign we = {bus.CAN4_WE, bus.CAN3_WE, bus.CAN2_WE, bus.CAN1_WE};
   assign rx = {CAN_RX4, CAN_RX3, CAN_RX2, CAN_RX1};

   assign bus.CAN1_DO = dout[0];
   assign bus.CAN2_DO = dout[1];
   assign bus.CAN3_DO = dout[2];
   assign bus.CAN4_DO = dout[3];

   assign CAN_TX1 = tx[0];
   assign CAN_TX2 = tx[1];
   assign CAN_TX3 = tx[2];
   assign CAN_TX4 = tx[3];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      can_if_chan #(
         .CH_CODE (CH_CODE[g]),
         .NREG    (NREG),
         .SYNC_FF (SYNC_FF)
      ) u_chan (
         .clk    (OPB_CLK),
         .rst    (OPB_RST),
         .di     (bus.OPB_DI),
         .addr   (bus.OPB_ADDR),
         .re     (re[g]),
         .we     (we[g]),
         .dout   (dout[g]),
         .can_tx (tx[g]),
         .can_rx (rx[g])
      );
   end

endmodule

// File: tb/tb_can_if_quad.sv
// Randomised bench for can_if_quad against a behavioural
// register-map model, plus directed boundary cases.
module tb_can_if_quad;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] tx;
   logic [3:0] rx = 4'hF;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_mbx [4][8];
   logic        m_en   [4];
   logic        m_lvl  [4];
   logic        m_fall [4];
   logic [31:0] m_do   [4];

   can_if_quad_if bus ();

   can_if_quad dut (
      .OPB_CLK (clk),
      .OPB_RST (rst),
      .bus     (bus.slave),
      .CAN_TX1 (tx[0]),
      .CAN_TX2 (tx[1]),
      .CAN_TX3 (tx[2]),
      .CAN_TX4 (tx[3]),
      .CAN_RX1 (rx[0]),
      .CAN_RX2 (rx[1]),
      .CAN_RX3 (rx[2]),
      .CAN_RX4 (rx[3])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] get_do(input int c);
      case (c)
         0: return bus.CAN1_DO;
         1: return bus.CAN2_DO;
         2: return bus.CAN3_DO;
         default: return bus.CAN4_DO;
      endcase
   endfunction

   task automatic set_strobes(input logic [3:0] re, input logic [3:0] we);
      {bus.CAN4_RE, bus.CAN3_RE, bus.CAN2_RE, bus.CAN1_RE} = re;
      {bus.CAN4_WE, bus.CAN3_WE, bus.CAN2_WE, bus.CAN1_WE} = we;
   endtask

   task automatic model_clear();
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 8; w++) m_mbx[c][w] = '0;
         m_en[c] = 0; m_lvl[c] = 0; m_fall[c] = 0; m_do[c] = '0;
      end
   endtask

   // Register map as seen by software; RX is idle-high outside the RX test
   task automatic model(input logic [3:0] re, input logic [3:0] we,
                        input logic [15:0] a, input logic [31:0] d);
      for (int c = 0; c < 4; c++) begin
         bit hit = (a[14:11] == (4'b1 << c));
         int w = int'(a[4:2]);
         logic [31:0] rv;
         if (a[15])
            rv = (w == 0) ? {29'd0, m_lvl[c], m_en[c], 1'b0} :
                 (w == 1) ? {30'd0, m_fall[c], 1'b1} : 32'd0;
         else
            rv = m_mbx[c][w];
         if (re[c]) begin
            m_do[c] = hit ? rv : 32'd0;
            if (hit && a[15] && w == 1) m_fall[c] = 0;
         end
         if (we[c] && hit) begin
            if (!a[15]) begin
               m_mbx[c][w] = d;
            end else if (w == 0) begin
               m_en[c]  = d[1];
               m_lvl[c] = d[2];
               if (d[0]) begin
                  for (int k = 0; k < 8; k++) m_mbx[c][k] = '0;
                  m_fall[c] = 0;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("do%0d", c + 1), get_do(c), m_do[c]);
         chk($sformatf("tx%0d", c + 1), 32'(tx[c]),
             32'(m_en[c] ? m_lvl[c] : 1'b1));
      end
   endtask

   task automatic op(input logic [3:0] re, input logic [3:0] we,
                     input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.OPB_ADDR = a;
      bus.OPB_DI   = d;
      set_strobes(re, we);
      model(re, we, a, d);
      @(posedge clk);
      #1;
      set_strobes(4'h0, 4'h0);
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [15:0] mb_a [4];
   logic [15:0] ct_a [4];
   logic [31:0] dat  [4];

   initial begin
      mb_a = '{16'h0800, 16'h1000, 16'h2000, 16'h4000};
      ct_a = '{16'h8800, 16'h9000, 16'hA000, 16'hC000};
      dat  = '{32'h12345678, 32'hAABBCCDD, 32'h55AA55AA, 32'hDEADBEEF};
      bus.OPB_ADDR = '0;
      bus.OPB_DI   = '0;
      set_strobes(4'h0, 4'h0);
      model_clear();

      #12;
      check_all();
      idle(2);
      rst = 1'b0;

      for (int c = 0; c < 4; c++) begin
         op(4'b1 << c, 4'h0, ct_a[c] | 16'h4, 32'd0);
         chk("stat_idle", get_do(c), 32'h1);
      end

      for (int c = 0; c < 4; c++) begin
         op(4'h0, 4'b1 << c, mb_a[c], dat[c]);
         op(4'h0, 4'b1 << c, ct_a[c], 32'd0);
         op(4'b1 << c, 4'h0, mb_a[c], 32'd0);
         chk($sformatf("rd%0d", c + 1), get_do(c), dat[c]);
      end
      for (int c = 0; c < 4; c++) begin
         op(4'b1 << c, 4'h0, mb_a[c], 32'd0);
         chk($sformatf("iso%0d", c + 1), get_do(c), dat[c]);
      end

      op(4'h0, 4'b0010, 16'h0800, 32'hFFFFFFFF);
      op(4'b0010, 4'h0, 16'h1000, 32'd0);
      chk("mismatch", bus.CAN2_DO, 32'hAABBCCDD);
      op(4'b0010, 4'h0, 16'h0800, 32'd0);
      chk("rej_rd", bus.CAN2_DO, 32'h0);

      op(4'h0, 4'b0100, 16'hA000, 32'h6);
      chk("tx3_en_hi", 32'(tx[2]), 32'h1);
      op(4'h0, 4'b0100, 16'hA000, 32'h2);
      chk("tx3_en_lo", 32'(tx[2]), 32'h0);
      op(4'h0, 4'b0100, 16'hA000, 32'h4);
      chk("tx3_dis", 32'(tx[2]), 32'h1);
      op(4'b0100, 4'b0100, 16'hA000, 32'h1);
      chk("ctrl_rdw", bus.CAN3_DO, 32'h4);
      op(4'b0100, 4'h0, 16'h2000, 32'd0);
      chk("srst_mbx", bus.CAN3_DO, 32'h0);

      @(negedge clk);
      rx[3] = 1'b0;
      idle(3);
      rx[3] = 1'b1;
      idle(5);
      m_fall[3] = 1;
      op(4'b1000, 4'h0, 16'hC004, 32'd0);
      chk("stat_fall", bus.CAN4_DO, 32'h3);
      op(4'b1000, 4'h0, 16'hC004, 32'd0);
      chk("stat_clr", bus.CAN4_DO, 32'h1);

      for (int i = 0; i < 400; i++) begin
         int          sel = $urandom_range(0, 4);
         logic [3:0]  code;
         logic        ctl = ($urandom_range(0, 3) == 0);
         logic [15:0] a;
         logic [31:0] d = $urandom;
         code = (sel == 4) ? 4'($urandom) : 4'(1 << sel);
         a = {ctl, code, 6'($urandom), 3'($urandom), 2'($urandom)};
         if (ctl && $urandom_range(0, 7) != 0) d[0] = 1'b0;
         op(4'($urandom), 4'($urandom) & 4'($urandom), a, d);
      end

      @(negedge clk);
      bus.OPB_ADDR = 16'h0800;
      bus.OPB_DI   = 32'hCAFEF00D;
      set_strobes(4'h0, 4'b0001);
      #1 rst = 1'b1;
      model_clear();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      set_strobes(4'h0, 4'h0);
      rst = 1'b0;
      op(4'b0001, 4'h0, 16'h0800, 32'd0);
      chk("rst_lost_wr", bus.CAN1_DO, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
